// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the nibble-memory loader and the core's memory port mux.
package mem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERROR = 3'd6
    } state_t;

    localparam logic MEM_RD = 1'b0;
    localparam logic MEM_WR = 1'b1;

    // A load is in progress in every state except the three resting ones.
    function automatic logic state_busy(input state_t s);
        return (s == ST_WAIT) || (s == ST_WRITE) || (s == ST_READ) || (s == ST_CHECK);
    endfunction

    function automatic logic state_mem_sel(input state_t s);
        return (s == ST_WRITE) || (s == ST_READ);
    endfunction

endpackage

// File: rtl/mem_loader.sv
// Streams DATA_W-bit words into consecutive memory addresses from 0, with optional read-back verify.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 4,
    parameter int unsigned DEPTH  = 32,
    parameter bit          VERIFY = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ready,
    output logic              o_mem_sel,
    output logic              o_mem_rw,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wData,
    input  logic [DATA_W-1:0] i_mem_rData,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [ADDR_W-1:0] o_err_addr,
    output logic [ADDR_W:0]   o_count
);

    localparam int unsigned     CNT_W     = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              state;
    state_t              state_n;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wbuf;
    logic                accept;
    logic                mismatch;
    logic                advance;

    // Next state; i_start overrides everything but reset and drops any in-flight word.
    always_comb begin
        state_n  = state;
        accept   = 1'b0;
        mismatch = 1'b0;
        advance  = 1'b0;
        if (i_start) begin
            state_n = ST_WAIT;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (i_valid) begin
                        accept  = 1'b1;
                        state_n = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (VERIFY) begin
                        state_n = ST_READ;
                    end else begin
                        advance = 1'b1;
                        state_n = (addr == LAST_ADDR) ? ST_DONE : ST_WAIT;
                    end
                end
                ST_READ: begin
                    state_n = ST_CHECK;
                end
                ST_CHECK: begin
                    if (i_mem_rData != wbuf) begin
                        mismatch = 1'b1;
                        state_n  = ST_ERROR;
                    end else begin
                        advance = 1'b1;
                        state_n = (addr == LAST_ADDR) ? ST_DONE : ST_WAIT;
                    end
                end
                default: begin
                    state_n = state;
                end
            endcase
        end
    end

    // State, datapath and every output are registered; outputs are decoded from state_n.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            addr        <= '0;
            wbuf        <= '0;
            o_ready     <= 1'b0;
            o_mem_sel   <= 1'b0;
            o_mem_rw    <= MEM_RD;
            o_mem_addr  <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
            o_err_addr  <= '0;
            o_count     <= '0;
        end else begin
            state     <= state_n;
            o_ready   <= (state_n == ST_WAIT);
            o_mem_sel <= state_mem_sel(state_n);
            o_mem_rw  <= (state_n == ST_WRITE) ? MEM_WR : MEM_RD;
            o_busy    <= state_busy(state_n);
            o_done    <= (state_n == ST_DONE);
            o_err     <= (state_n == ST_ERROR);

            if (i_start) begin
                addr       <= '0;
                o_count    <= '0;
                o_err_addr <= '0;
            end else begin
                // Memory address/data only move when a new word is accepted, so they hold while idle.
                if (accept) begin
                    wbuf       <= i_data;
                    o_mem_addr <= addr;
                end
                if (advance) begin
                    o_count <= o_count + CNT_W'(1);
                    if (addr != LAST_ADDR) begin
                        addr <= addr + ADDR_W'(1);
                    end
                end
                if (mismatch) begin
                    o_err_addr <= addr;
                end
            end
        end
    end

    assign o_mem_wData = wbuf;

endmodule

// File: tb/tb_mem_loader.sv
// Randomized self-checking bench for mem_loader: one verifying instance and one write-only instance.
`timescale 1ns/1ps
module tb_mem_loader;

    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 4;
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned DEPTH = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Verifying instance
    logic          s1, v1, r1, sel1, rw1, busy1, done1, err1;
    logic [DW-1:0] d1, wd1, rd1;
    logic [AW-1:0] addr1, eaddr1;
    logic [CW-1:0] cnt1;
    // Write-only instance
    logic          s2, v2, r2, sel2, rw2, busy2, done2, err2;
    logic [DW-1:0] d2, wd2, rd2;
    logic [AW-1:0] addr2, eaddr2;
    logic [CW-1:0] cnt2;

    mem_loader #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .VERIFY(1'b1)) dut_v (
        .i_clk(clk), .i_rst(rst), .i_start(s1), .i_valid(v1), .i_data(d1),
        .o_ready(r1), .o_mem_sel(sel1), .o_mem_rw(rw1), .o_mem_addr(addr1),
        .o_mem_wData(wd1), .i_mem_rData(rd1), .o_busy(busy1), .o_done(done1),
        .o_err(err1), .o_err_addr(eaddr1), .o_count(cnt1)
    );

    mem_loader #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .VERIFY(1'b0)) dut_w (
        .i_clk(clk), .i_rst(rst), .i_start(s2), .i_valid(v2), .i_data(d2),
        .o_ready(r2), .o_mem_sel(sel2), .o_mem_rw(rw2), .o_mem_addr(addr2),
        .o_mem_wData(wd2), .i_mem_rData(rd2), .o_busy(busy2), .o_done(done2),
        .o_err(err2), .o_err_addr(eaddr2), .o_count(cnt2)
    );

    // Synchronous 32x4 memories, read data valid the cycle after the read edge.
    logic [DW-1:0] mem1 [DEPTH];
    logic [DW-1:0] mem2 [DEPTH];
    int acc1 = 0, wcnt1 = 0, rcnt1 = 0, wf1 = 0, wcnt2 = 0, rcnt2 = 0, cyc = 0;
    int bad_addr = -1;
    int wlog1[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (sel1 === 1'b1) begin
            acc1 <= acc1 + 1;
            if (rw1 === 1'b1) begin
                mem1[addr1] <= wd1;
                wcnt1 <= wcnt1 + 1;
                if (wd1 === 4'hF) wf1 <= wf1 + 1;
                wlog1.push_back(int'(addr1));
            end else begin
                rcnt1 <= rcnt1 + 1;
                rd1   <= (int'(addr1) == bad_addr) ? 4'h0 : mem1[addr1];
            end
        end
    end

    always @(posedge clk) begin
        if (sel2 === 1'b1) begin
            if (rw2 === 1'b1) begin
                mem2[addr2] <= wd2;
                wcnt2 <= wcnt2 + 1;
            end else begin
                rcnt2 <= rcnt2 + 1;
                rd2   <= mem2[addr2];
            end
        end
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start1();
        s1 = 1'b1; tick(); s1 = 1'b0;
    endtask

    // Waits (bounded) for o_ready, offers one word, returns the accepting edge number or -1.
    task automatic send1(input logic [DW-1:0] d, output int edge_no);
        int w = 0;
        while (r1 !== 1'b1 && w < 20) begin tick(); w++; end
        if (r1 !== 1'b1) begin edge_no = -1; return; end
        v1 = 1'b1; d1 = d; tick(); v1 = 1'b0; d1 = DW'($urandom);
        edge_no = cyc;
    endtask

    task automatic send2(input logic [DW-1:0] d, output int edge_no);
        int w = 0;
        while (r2 !== 1'b1 && w < 20) begin tick(); w++; end
        if (r2 !== 1'b1) begin edge_no = -1; return; end
        v2 = 1'b1; d2 = d; tick(); v2 = 1'b0; d2 = DW'($urandom);
        edge_no = cyc;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        vectors++;
        if ({r1, sel1, rw1, addr1, wd1, busy1, done1, err1, eaddr1, cnt1} !== '0) begin
            miscompares++;
            $display("FAIL reset_v: outs=%0h required 0", {r1, sel1, rw1, addr1, wd1, busy1, done1, err1, eaddr1, cnt1});
        end
        vectors++;
        if ({r2, sel2, rw2, addr2, wd2, busy2, done2, err2, eaddr2, cnt2} !== '0) begin
            miscompares++;
            $display("FAIL reset_w: outs=%0h required 0", {r2, sel2, rw2, addr2, wd2, busy2, done2, err2, eaddr2, cnt2});
        end
    endtask

    task automatic test_full_load();
        logic [DW-1:0] exp_mem [DEPTH];
        int e, prev = -1, bad_gaps = 0, to = 0, bad = 0;
        start1();
        for (int a = 0; a < DEPTH; a++) begin
            exp_mem[a] = DW'(a) ^ 4'hA;
            send1(exp_mem[a], e);
            if (e < 0) begin to++; break; end
            if (prev >= 0 && e - prev != 4) bad_gaps++;
            prev = e;
        end
        for (int i = 0; i < 10 && done1 !== 1'b1; i++) tick();
        vectors++;
        if (to != 0) begin miscompares++; $display("FAIL full_ready_timeout: timeouts=%0d required 0", to); end
        vectors++;
        if (bad_gaps != 0) begin miscompares++; $display("FAIL full_gap: gaps_not_4=%0d required 0", bad_gaps); end
        vectors++;
        if ({done1, err1, busy1, cnt1} !== {1'b1, 1'b0, 1'b0, CW'(DEPTH)}) begin
            miscompares++;
            $display("FAIL full_status: done=%0b err=%0b busy=%0b count=%0d required 1 0 0 %0d", done1, err1, busy1, cnt1, DEPTH);
        end
        for (int a = 0; a < DEPTH; a++) if (mem1[a] !== exp_mem[a]) bad++;
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL full_mem: bad_words=%0d required 0", bad); end
    endtask

    task automatic test_mismatch();
        logic [DW-1:0] exp_mem [8];
        int e, to = 0, snap, bad = 0;
        bad_addr = 7;
        start1();
        for (int a = 0; a < 8; a++) begin
            exp_mem[a] = (a == 7) ? 4'h5 : DW'($urandom);
            send1(exp_mem[a], e);
            if (e < 0) to++;
        end
        for (int i = 0; i < 10 && err1 !== 1'b1; i++) tick();
        vectors++;
        if (to != 0 || err1 !== 1'b1) begin miscompares++; $display("FAIL mis_err: err=%0b timeouts=%0d required 1 0", err1, to); end
        vectors++;
        if (eaddr1 !== AW'(7)) begin miscompares++; $display("FAIL mis_err_addr: got %0d required 7", eaddr1); end
        vectors++;
        if ({cnt1, done1, busy1, r1} !== {CW'(7), 3'b000}) begin
            miscompares++;
            $display("FAIL mis_status: count=%0d done=%0b busy=%0b ready=%0b required 7 0 0 0", cnt1, done1, busy1, r1);
        end
        snap = acc1;
        repeat (6) tick();
        vectors++;
        if (acc1 != snap || sel1 !== 1'b0) begin
            miscompares++;
            $display("FAIL mis_quiet: extra_accesses=%0d sel=%0b required 0 0", acc1 - snap, sel1);
        end
        for (int a = 0; a < 8; a++) if (mem1[a] !== exp_mem[a]) bad++;
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL mis_mem: bad_words=%0d required 0", bad); end
        bad_addr = -1;
    endtask

    task automatic test_restart();
        int e, to = 0, ws0, ws, hits10 = 0;
        logic [DW-1:0] w0;
        start1();
        vectors++;
        if ({err1, eaddr1, done1} !== '0) begin
            miscompares++;
            $display("FAIL rst_clear: err=%0b err_addr=%0d done=%0b required 0 0 0", err1, eaddr1, done1);
        end
        ws0 = wlog1.size();
        for (int a = 0; a < 10; a++) begin
            send1(DW'($urandom), e);
            if (e < 0) to++;
        end
        tick();
        vectors++;
        if (to != 0 || {sel1, rw1, cnt1} !== {2'b10, CW'(9)}) begin
            miscompares++;
            $display("FAIL rs_in_read: sel=%0b rw=%0b count=%0d timeouts=%0d required 1 0 9 0", sel1, rw1, cnt1, to);
        end
        s1 = 1'b1; tick(); s1 = 1'b0;
        vectors++;
        if ({cnt1, r1, sel1} !== {CW'(0), 2'b10}) begin
            miscompares++;
            $display("FAIL rs_restart: count=%0d ready=%0b sel=%0b required 0 1 0", cnt1, r1, sel1);
        end
        ws = wlog1.size();
        w0 = DW'($urandom);
        send1(w0, e);
        repeat (3) tick();
        vectors++;
        if (e < 0 || wlog1.size() != ws + 1 || wlog1[ws] != 0 || mem1[0] !== w0) begin
            miscompares++;
            $display("FAIL rs_first_write: new_writes=%0d mem0=%0h required 1 write to addr 0 of %0h", wlog1.size() - ws, mem1[0], w0);
        end
        vectors++;
        if (cnt1 !== CW'(1)) begin miscompares++; $display("FAIL rs_count: got %0d required 1", cnt1); end
        for (int i = ws0; i < wlog1.size(); i++) if (wlog1[i] == 10) hits10++;
        vectors++;
        if (hits10 != 0) begin miscompares++; $display("FAIL rs_no_addr10: writes_to_10=%0d required 0", hits10); end
    endtask

    task automatic test_ignored();
        int accepted = 0, w0, f0, bad = 0;
        start1();
        w0 = wcnt1; f0 = wf1;
        for (int i = 0; i < 400 && done1 !== 1'b1; i++) begin
            v1 = 1'b1;
            d1 = (r1 === 1'b1) ? 4'h3 : 4'hF;
            if (r1 === 1'b1) accepted++;
            tick();
        end
        v1 = 1'b0;
        vectors++;
        if ({done1, err1, cnt1} !== {2'b10, CW'(DEPTH)} || accepted != DEPTH) begin
            miscompares++;
            $display("FAIL ign_status: done=%0b err=%0b count=%0d accepted=%0d required 1 0 %0d %0d", done1, err1, cnt1, accepted, DEPTH, DEPTH);
        end
        vectors++;
        if (wcnt1 - w0 != DEPTH || wf1 != f0) begin
            miscompares++;
            $display("FAIL ign_writes: writes=%0d f_writes=%0d required %0d 0", wcnt1 - w0, wf1 - f0, DEPTH);
        end
        for (int a = 0; a < DEPTH; a++) if (mem1[a] !== 4'h3) bad++;
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL ign_mem: non_3_words=%0d required 0", bad); end
    endtask

    task automatic test_reset_mid();
        int e, to = 0, snap, bad = 0;
        start1();
        for (int a = 0; a < 5; a++) begin
            send1(DW'($urandom), e);
            if (e < 0) to++;
        end
        vectors++;
        if (to != 0 || {sel1, rw1, addr1} !== {2'b11, AW'(4)}) begin
            miscompares++;
            $display("FAIL rm_in_write: sel=%0b rw=%0b addr=%0d required 1 1 4", sel1, rw1, addr1);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        vectors++;
        if ({r1, sel1, rw1, addr1, wd1, busy1, done1, err1, eaddr1, cnt1} !== '0) begin
            miscompares++;
            $display("FAIL rm_reset_vals: outs=%0h required 0", {r1, sel1, rw1, addr1, wd1, busy1, done1, err1, eaddr1, cnt1});
        end
        snap = acc1;
        repeat (8) begin
            v1 = 1'($urandom); d1 = DW'($urandom);
            tick();
            if (sel1 !== 1'b0 || r1 !== 1'b0) bad++;
        end
        v1 = 1'b0;
        vectors++;
        if (bad != 0 || acc1 != snap) begin
            miscompares++;
            $display("FAIL rm_quiet: active_cycles=%0d accesses=%0d required 0 0", bad, acc1 - snap);
        end
    endtask

    task automatic test_verify0();
        logic [DW-1:0] exp_mem [DEPTH];
        int e, first = -1, prev = -1, bad_gaps = 0, to = 0, bad = 0, w0, r0, done_edge;
        w0 = wcnt2; r0 = rcnt2;
        s2 = 1'b1; tick(); s2 = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            exp_mem[a] = DW'($urandom);
            send2(exp_mem[a], e);
            if (e < 0) begin to++; break; end
            if (first < 0) first = e;
            if (prev >= 0 && e - prev != 2) bad_gaps++;
            prev = e;
        end
        for (int i = 0; i < 10 && done2 !== 1'b1; i++) tick();
        done_edge = cyc;
        vectors++;
        if (to != 0 || bad_gaps != 0) begin
            miscompares++;
            $display("FAIL w_gap: gaps_not_2=%0d timeouts=%0d required 0 0", bad_gaps, to);
        end
        // Two cycles per word: done shows after the 2*DEPTH-1'th edge past the first acceptance.
        vectors++;
        if (done2 !== 1'b1 || done_edge - first != 2 * DEPTH - 1) begin
            miscompares++;
            $display("FAIL w_done_time: done=%0b edges=%0d required 1 %0d", done2, done_edge - first, 2 * DEPTH - 1);
        end
        vectors++;
        if ({cnt2, err2} !== {CW'(DEPTH), 1'b0} || rcnt2 != r0 || wcnt2 - w0 != DEPTH) begin
            miscompares++;
            $display("FAIL w_status: count=%0d err=%0b reads=%0d writes=%0d required %0d 0 0 %0d", cnt2, err2, rcnt2 - r0, wcnt2 - w0, DEPTH, DEPTH);
        end
        for (int a = 0; a < DEPTH; a++) if (mem2[a] !== exp_mem[a]) bad++;
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL w_mem: bad_words=%0d required 0", bad); end
    endtask

    initial begin
        rst = 1'b1;
        s1 = 1'b0; v1 = 1'b0; d1 = '0;
        s2 = 1'b0; v2 = 1'b0; d2 = '0;
        test_reset();
        test_full_load();
        test_mismatch();
        test_restart();
        test_ignored();
        test_reset_mid();
        test_verify0();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
